// File: rtl/bin2gray_counter_if.sv
// rtl/bin2gray_counter_if.sv - valid/ready stream carrying the Gray code, binary count and wrap flag
//
// Signals
//   out_valid : current code is valid (producer)
//   out_ready : consumer accepts the current code (consumer)
//   gray      : registered Gray code of the count (producer)
//   bin       : registered binary count (producer)
//   wrap      : one-cycle pulse after a step across the max/0 boundary (producer)
// Modports: master = producer (counter), slave = consumer.

interface bin2gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             wrap;

    modport master (
        output out_valid,
        output gray,
        output bin,
        output wrap,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  gray,
        input  bin,
        input  wrap,
        output out_ready
    );
endinterface

// File: rtl/bin2gray_counter.sv
// rtl/bin2gray_counter.sv - up/down binary counter presented as a registered Gray code stream
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   en       : stream enable, out_valid follows it one cycle later
//   up       : step direction on accept (1 = +1, 0 = -1)
//   load     : synchronous load strobe, wins over an accept in the same cycle
//   load_bin : binary value to load
//   stream   : master side of the output stream (out_valid/out_ready/gray/bin/wrap)

module bin2gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [WIDTH-1:0]        load_bin,
    bin2gray_counter_if.master      stream
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic             accept;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic             wrap_next;

    assign accept = stream.out_valid & stream.out_ready;

    always_comb begin
        bin_next  = stream.bin;
        wrap_next = 1'b0;
        if (load) begin
            // A coincident accept is consumed without stepping.
            bin_next = load_bin;
        end else if (accept) begin
            if (up) begin
                bin_next  = stream.bin + ONE;
                wrap_next = (stream.bin == ALL_ONES);
            end else begin
                bin_next  = stream.bin - ONE;
                wrap_next = (stream.bin == '0);
            end
        end
    end

    // Encode the next binary value so gray and bin land on the same edge;
    // the output is a flop, never a combinational decode of bin.
    assign gray_next = bin_next ^ (bin_next >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream.bin       <= '0;
            stream.gray      <= '0;
            stream.out_valid <= 1'b0;
            stream.wrap      <= 1'b0;
        end else begin
            stream.bin       <= bin_next;
            stream.gray      <= gray_next;
            stream.out_valid <= en;
            stream.wrap      <= wrap_next;
        end
    end

endmodule

// File: tb/tb_bin2gray_counter.sv
// tb/tb_bin2gray_counter.sv - self-checking bench for bin2gray_counter

module tb_bin2gray_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] prev_gray = '0;
    logic         skip_step = 1'b1;

    bin2gray_counter_if #(.WIDTH(W)) sif ();

    bin2gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .stream   (sif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         en;
        logic         up;
        logic         load;
        logic [W-1:0] load_bin;
        logic         ready;
        logic         exp_valid;
        logic [W-1:0] exp_gray;
        logic [W-1:0] exp_bin;
        logic         exp_wrap;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic e, logic u, logic l, logic [W-1:0] lb, logic r,
                                logic v, logic [W-1:0] g, logic [W-1:0] b, logic wr);
        vec_t t;
        t.en = e; t.up = u; t.load = l; t.load_bin = lb; t.ready = r;
        t.exp_valid = v; t.exp_gray = g; t.exp_bin = b; t.exp_wrap = wr;
        return t;
    endfunction

    function automatic logic [W-1:0] g2b(logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(string name, logic v, logic [W-1:0] g, logic [W-1:0] b, logic wr);
        chk({name, ".valid"}, 32'(sif.out_valid), 32'(v));
        chk({name, ".gray"},  32'(sif.gray),      32'(g));
        chk({name, ".bin"},   32'(sif.bin),       32'(b));
        chk({name, ".wrap"},  32'(sif.wrap),      32'(wr));
    endtask

    // One clock edge, then sampling 1 time unit later plus the invariant checks.
    task automatic tick();
        logic was_load;
        was_load = load;
        @(posedge clk);
        #1;
        chk("inv_gray_eq_enc_bin", 32'(sif.gray), 32'(sif.bin ^ (sif.bin >> 1)));
        chk("inv_gray2bin",        32'(g2b(sif.gray)), 32'(sif.bin));
        if (!skip_step && !was_load && (sif.gray != prev_gray))
            chk("inv_one_bit_step", $countones(sif.gray ^ prev_gray), 1);
        prev_gray = sif.gray;
        skip_step = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear before the next edge.
    task automatic pulse_reset(string name);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out(name, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        skip_step = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0000, 4'd0,  0);
        vecs[1]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0001, 4'd1,  0);
        vecs[2]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0011, 4'd2,  0);
        vecs[3]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0010, 4'd3,  0);
        vecs[4]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0110, 4'd4,  0);
        vecs[5]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0111, 4'd5,  0);
        vecs[6]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0101, 4'd6,  0);
        vecs[7]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b0100, 4'd7,  0);
        vecs[8]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b1100, 4'd8,  0);
        vecs[9]  = mk(1, 1, 0, 4'h0, 1, 1, 4'b1101, 4'd9,  0);
        vecs[10] = mk(1, 1, 0, 4'h0, 1, 1, 4'b1111, 4'd10, 0);
        vecs[11] = mk(1, 1, 0, 4'h0, 1, 1, 4'b1110, 4'd11, 0);
        vecs[12] = mk(1, 1, 0, 4'h0, 1, 1, 4'b1010, 4'd12, 0);
        vecs[13] = mk(1, 1, 0, 4'h0, 1, 1, 4'b1011, 4'd13, 0);
        vecs[14] = mk(1, 1, 0, 4'h0, 1, 1, 4'b1001, 4'd14, 0);
        vecs[15] = mk(1, 1, 0, 4'h0, 1, 1, 4'b1000, 4'd15, 0);
        vecs[16] = mk(1, 1, 0, 4'h0, 1, 1, 4'b0000, 4'd0,  1);
        // en falls: the last valid cycle still accepts and steps, then the count holds.
        vecs[17] = mk(0, 1, 0, 4'h0, 1, 0, 4'b0001, 4'd1,  0);
        vecs[18] = mk(0, 1, 0, 4'h0, 1, 0, 4'b0001, 4'd1,  0);

        sif.out_ready = 1'b0;

        // Reset state while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;

        // Up count across the wrap and the en-fall tail.
        for (int i = 0; i < 19; i++) begin
            en = vecs[i].en; up = vecs[i].up; load = vecs[i].load;
            load_bin = vecs[i].load_bin; sif.out_ready = vecs[i].ready;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_gray,
                    vecs[i].exp_bin, vecs[i].exp_wrap);
        end

        // Backpressure at gray 0110.
        pulse_reset("rst_bp");
        en = 1'b1; up = 1'b1; sif.out_ready = 1'b1;
        repeat (5) tick();
        chk_out("bp_start", 1'b1, 4'b0110, 4'd4, 1'b0);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp_hold%0d", i), 1'b1, 4'b0110, 4'd4, 1'b0);
        end
        sif.out_ready = 1'b1;
        tick();
        chk_out("bp_release", 1'b1, 4'b0111, 4'd5, 1'b0);

        // Load colliding with an accept: load wins, no step.
        load = 1'b1; load_bin = 4'b1010;
        tick();
        chk_out("load_collide", 1'b1, 4'b1111, 4'b1010, 1'b0);
        load = 1'b0;
        tick();
        chk_out("after_load", 1'b1, 4'b1110, 4'b1011, 1'b0);

        // Load works while out_valid is low.
        en = 1'b0;
        tick();
        chk_out("en_fall_step", 1'b0, 4'b1010, 4'b1100, 1'b0);
        tick();
        chk_out("idle_hold", 1'b0, 4'b1010, 4'b1100, 1'b0);
        load = 1'b1; load_bin = 4'b0011;
        tick();
        chk_out("idle_load", 1'b0, 4'b0010, 4'b0011, 1'b0);

        // Async reset mid-stream at gray 1101.
        en = 1'b1; load = 1'b1; load_bin = 4'd9; sif.out_ready = 1'b0;
        tick();
        chk_out("pre_rst", 1'b1, 4'b1101, 4'd9, 1'b0);
        load = 1'b0; sif.out_ready = 1'b1;
        pulse_reset("rst_mid");
        tick();
        chk_out("rst_restart0", 1'b1, 4'b0000, 4'd0, 1'b0);
        tick();
        chk_out("rst_restart1", 1'b1, 4'b0001, 4'd1, 1'b0);

        // Down count from reset, wrapping below zero.
        en = 1'b0;
        pulse_reset("rst_dn");
        en = 1'b1; up = 1'b0; sif.out_ready = 1'b1;
        tick();
        chk_out("dn0", 1'b1, 4'b0000, 4'd0, 1'b0);
        tick();
        chk_out("dn1", 1'b1, 4'b1000, 4'b1111, 1'b1);
        tick();
        chk_out("dn2", 1'b1, 4'b1001, 4'b1110, 1'b0);

        // Direction toggling between back-to-back accepts.
        up = 1'b1;
        tick();
        chk_out("tog_up", 1'b1, 4'b1000, 4'b1111, 1'b0);
        up = 1'b1;
        tick();
        chk_out("tog_wrap", 1'b1, 4'b0000, 4'd0, 1'b1);
        up = 1'b0;
        tick();
        chk_out("tog_dn", 1'b1, 4'b1000, 4'b1111, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
